// File: rtl/es_sram_sched_if.sv
// Handshake bundle between the entropy SRAM scheduler and its surroundings.
// The scheduler takes the slave side; request sources, sink and SRAM take the master side.
interface es_sram_sched_if #(
  parameter int ADDR_W = 11
);
  logic              flush;
  logic              latch_req;
  logic              jitter_req;
  logic              sink_ready;

  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_sel_jitter;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_valid;
  logic              rd_is_jitter;
  logic [ADDR_W-1:0] latch_count;
  logic [ADDR_W-1:0] jitter_count;
  logic              drop_latch;
  logic              drop_jitter;
  logic              primed;

  modport slave (
    input  flush, latch_req, jitter_req, sink_ready,
    output wr_en, wr_addr, wr_sel_jitter, rd_en, rd_addr, rd_valid, rd_is_jitter,
           latch_count, jitter_count, drop_latch, drop_jitter, primed
  );

  modport master (
    output flush, latch_req, jitter_req, sink_ready,
    input  wr_en, wr_addr, wr_sel_jitter, rd_en, rd_addr, rd_valid, rd_is_jitter,
           latch_count, jitter_count, drop_latch, drop_jitter, primed
  );
endinterface

// File: rtl/es_sram_sched.sv
// Port A / port B scheduler for the dual-port entropy SRAM: two circular queues
// (latch words on even addresses, jitter words on odd) with round-robin write and read arbitration.
module es_sram_sched #(
  parameter int ADDR_W       = 11,
  parameter int RD_LAT       = 2,
  parameter int PRIME_THRESH = 32
) (
  input  logic             clk,
  input  logic             rst,
  es_sram_sched_if.slave   bus
);

  localparam int                PW = ADDR_W - 1;
  localparam logic [ADDR_W-1:0] QD = {1'b1, {PW{1'b0}}};

  logic [PW-1:0]     wr_ptr_l_q, wr_ptr_l_d, wr_ptr_j_q, wr_ptr_j_d;
  logic [PW-1:0]     rd_ptr_l_q, rd_ptr_l_d, rd_ptr_j_q, rd_ptr_j_d;
  logic [ADDR_W-1:0] latch_cnt_q, latch_cnt_d, jitter_cnt_q, jitter_cnt_d;
  logic              wr_rr_q, wr_rr_d, rd_rr_q, rd_rr_d;
  logic              primed_q, primed_d;
  logic [RD_LAT-1:0] vld_q, vld_d, typ_q, typ_d;

  logic              clr;
  logic              wl, wj, gnt_l, gnt_j;
  logic              rd_go, rl, rj, rgnt_l, rgnt_j;
  logic [ADDR_W:0]   total;

  always_comb begin
    // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
    clr    = rst | bus.flush;

    wl     = bus.latch_req  & (latch_cnt_q  != QD);
    wj     = bus.jitter_req & (jitter_cnt_q != QD);
    gnt_l  = ~clr & wl & (~wj | ~wr_rr_q);
    gnt_j  = ~clr & wj & (~wl |  wr_rr_q);

    // Reads only see registered counts, so a word written this cycle is not readable yet.
    rd_go  = ~clr & primed_q & bus.sink_ready;
    rl     = latch_cnt_q  != '0;
    rj     = jitter_cnt_q != '0;
    rgnt_l = rd_go & rl & (~rj | ~rd_rr_q);
    rgnt_j = rd_go & rj & (~rl |  rd_rr_q);

    wr_ptr_l_d   = wr_ptr_l_q + PW'(gnt_l);
    wr_ptr_j_d   = wr_ptr_j_q + PW'(gnt_j);
    rd_ptr_l_d   = rd_ptr_l_q + PW'(rgnt_l);
    rd_ptr_j_d   = rd_ptr_j_q + PW'(rgnt_j);
    latch_cnt_d  = latch_cnt_q  + ADDR_W'(gnt_l) - ADDR_W'(rgnt_l);
    jitter_cnt_d = jitter_cnt_q + ADDR_W'(gnt_j) - ADDR_W'(rgnt_j);

    wr_rr_d = wr_rr_q ^ (~clr & wl & wj);
    rd_rr_d = rd_rr_q ^ (rd_go & rl & rj);

    total    = {1'b0, latch_cnt_q} + {1'b0, jitter_cnt_q};
    primed_d = primed_q | (total >= (ADDR_W+1)'(PRIME_THRESH));

    vld_d    = '0;
    typ_d    = '0;
    vld_d[0] = rgnt_l | rgnt_j;
    typ_d[0] = rgnt_j;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      typ_d[i] = typ_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      wr_ptr_l_q   <= '0;
      wr_ptr_j_q   <= '0;
      rd_ptr_l_q   <= '0;
      rd_ptr_j_q   <= '0;
      latch_cnt_q  <= '0;
      jitter_cnt_q <= '0;
      wr_rr_q      <= 1'b0;
      rd_rr_q      <= 1'b0;
      primed_q     <= 1'b0;
      vld_q        <= '0;
      typ_q        <= '0;
    end else begin
      wr_ptr_l_q   <= wr_ptr_l_d;
      wr_ptr_j_q   <= wr_ptr_j_d;
      rd_ptr_l_q   <= rd_ptr_l_d;
      rd_ptr_j_q   <= rd_ptr_j_d;
      latch_cnt_q  <= latch_cnt_d;
      jitter_cnt_q <= jitter_cnt_d;
      wr_rr_q      <= wr_rr_d;
      rd_rr_q      <= rd_rr_d;
      primed_q     <= primed_d;
      vld_q        <= vld_d;
      typ_q        <= typ_d;
    end
  end

  assign bus.wr_en         = gnt_l | gnt_j;
  assign bus.wr_addr       = gnt_j ? {wr_ptr_j_q, 1'b1} : {wr_ptr_l_q, 1'b0};
  assign bus.wr_sel_jitter = gnt_j;
  assign bus.rd_en         = rgnt_l | rgnt_j;
  assign bus.rd_addr       = rgnt_j ? {rd_ptr_j_q, 1'b1} : {rd_ptr_l_q, 1'b0};
  assign bus.rd_valid      = vld_q[RD_LAT-1];
  assign bus.rd_is_jitter  = typ_q[RD_LAT-1];
  assign bus.latch_count   = latch_cnt_q;
  assign bus.jitter_count  = jitter_cnt_q;
  assign bus.drop_latch    = bus.latch_req  & ~gnt_l & ~clr;
  assign bus.drop_jitter   = bus.jitter_req & ~gnt_j & ~clr;
  assign bus.primed        = primed_q;

endmodule

// File: doc/es_sram_sched.md
Name: es_sram_sched

Overview:
- Arbiter/scheduler for the dual-port entropy SRAM: port A write-only, port B read-only.
- The SRAM is split into two logical circular queues: even addresses hold latch-source words, odd addresses hold jitter-source words.
- Port A is shared between the latch and jitter writers with round-robin arbitration. Reads from port B are scheduled round-robin toward the bit compactor, with credit-style flow control and a read-start priming threshold.
- Sits between the 64 OHT health testers / ES inputs and the streaming_bit_compactor → que_fiao path.

Parameters:
- ADDR_W, 11, SRAM address width. Each queue has depth QD = 2^(ADDR_W-1) = 1024.
- RD_LAT, 2, cycles from read issue edge to valid SRAM QB data at the compactor input; must be ≥1.
- PRIME_THRESH, 32, total words (latch_count + jitter_count) required before reads are first enabled.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- flush  in  1  synchronous queue flush (same effect as rst on internal state)
- latch_req  in  1  latch word available this cycle (OR of latch valid bits)
- jitter_req  in  1  jitter word available this cycle (OR of jitter valid bits)
- sink_ready  in  1  downstream can absorb a read issued this cycle
- wr_en  out  1  port A write strobe (active high; top-level drives WENA=~wr_en)
- wr_addr  out  ADDR_W  port A address
- wr_sel_jitter  out  1  1: mux jitter ES word onto DA; 0: latch ES word
- rd_en  out  1  port B read issue (CENB=~rd_en)
- rd_addr  out  ADDR_W  port B address
- rd_valid  out  1  QB valid, aligned RD_LAT cycles after rd_en
- rd_is_jitter  out  1  type of the word on QB, qualifies rd_valid; selects the compactor mask
- latch_count  out  ADDR_W  latch queue occupancy, 0..QD
- jitter_count  out  ADDR_W  jitter queue occupancy, 0..QD
- drop_latch  out  1  pulse: latch_req not written this cycle
- drop_jitter  out  1  pulse: jitter_req not written this cycle
- primed  out  1  read scheduling enabled

Behaviour:
- State: wr_ptr_l, wr_ptr_j, rd_ptr_l, rd_ptr_j (ADDR_W-1 bits each, wrap modulo QD), two counts, wr_rr, rd_rr, primed, RD_LAT-deep valid/type shift register.
- Write arbitration (combinational from registered state):
  - wl = latch_req & (latch_count != QD); wj = jitter_req & (jitter_count != QD).
  - If only one of wl/wj is set, grant it. If both, grant the wr_rr side (0 = latch).
  - wr_rr toggles only on a contended grant.
  - Latch grant: wr_addr = {wr_ptr_l, 1'b0}, wr_sel_jitter = 0. Jitter grant: wr_addr = {wr_ptr_j, 1'b1}, wr_sel_jitter = 1.
  - wr_en = 1 on any grant. The granted pointer increments at the clock edge.
- Drops: drop_x = x_req & ~granted_x. This covers both a full queue and a lost arbitration. Drops are combinational; data is lost with no retry.
- Read scheduling, while primed & sink_ready:
  - rl = latch_count != 0; rj = jitter_count != 0.
  - Same round-robin rule as writes, using rd_rr. rd_rr toggles on every contended grant.
  - rd_addr = {rd_ptr_x, type}; rd_en = 1; the granted pointer increments at the edge.
  - If primed = 0 or sink_ready = 0: rd_en = 0 and pointers hold.
- Counts use registered values only. A word written at edge t is readable from cycle t+1; no same-cycle bypass.
  - Simultaneous write and read on the same queue: count unchanged.
  - Count is never incremented past QD (full blocks the write) and never decremented below 0 (empty blocks the read).
- primed:
  - Rises at the edge where registered latch_count + jitter_count ≥ PRIME_THRESH; first read may issue the cycle after.
  - Stays 1 until rst/flush, even if the queues drain.
- Read pipeline: rd_valid and rd_is_jitter equal rd_en and its granted type delayed exactly RD_LAT cycles.
- Flow-control contract: sink_ready=1 guarantees the sink absorbs any word issued that cycle. The block never stalls an in-flight read.
- rst or flush (flush has identical effect):
  - All pointers, counts, wr_rr, rd_rr, primed and the pipeline clear to 0.
  - In-flight rd_valid is killed the next cycle.
  - Next cycle outputs: wr_en/rd_en/rd_valid/drop_* follow requests; counts = 0; primed = 0.
  - Requests during the rst/flush cycle are not written, and drop_* stays 0 in that cycle.
- Reset values of registered-derived outputs: rd_valid = 0, rd_is_jitter = 0, latch_count = 0, jitter_count = 0, primed = 0. rd_en = 0 (since primed = 0).
- Address wrap: pointer QD-1 → 0; latch_count = QD exactly at full. The even/odd mapping is never broken.

Test Plan:
- Reset, then latch_req=1 only for 5 cycles → wr_addr 0,2,4,6,8; wr_sel_jitter=0; latch_count=5; rd_en stays 0 (primed=0).
- latch_req=jitter_req=1 for 4 cycles after reset → grants L,J,L,J at addrs 0,1,2,3; drop_jitter, drop_latch, drop_jitter, drop_latch alternate; counts 2/2.
- Fill to 32 words with sink_ready=1 → primed rises the edge count hits 32; first rd_en next cycle at addr 0; rd_valid follows exactly 2 cycles later with the correct rd_is_jitter.
- Latch-only writes 1024 times with sink_ready=0 → latch_count=1024, wr_addr wraps 2046→0; the 1025th request gives drop_latch=1 with no write; one read then reopens writes the next cycle.
- Steady state, write+read on the latch queue each cycle → latch_count constant; toggling sink_ready=0 for 3 cycles → rd_en=0 in those cycles and rd_valid gaps appear 2 cycles later.
- flush asserted with 2 reads in flight → rd_valid=0 from the next cycle; counts=0; primed=0; next write at addr 0/1.
